// File: rtl/ft245_bus_sched.sv
// ---------------------------------------------------------------------------
// ft245_bus_sched
//
// Half-duplex bus scheduler for an FTDI FT245-style synchronous FIFO port.
// It decides, cycle by cycle, whether the shared 8-bit data bus is being
// read (host -> FPGA), written (FPGA -> host) or left idle. It also
// generates the FTDI handshake strobes and the local buffer hand-off
// strobes. The data bus itself is not handled here; data_dir tells the
// pad logic when to drive it.
//
// Parameters
//   MAX_BURST    bytes moved per grant before re-arbitration (1..255)
//   TURN_CYCLES  idle cycles after oe_n rises before the FPGA may drive
//                the bus (1..3)
//
// Ports
//   clk          FT245 synchronous clock, rising edge
//   rst          synchronous active-high reset
//   ftdi_rde_n   FTDI has RX bytes (active low)
//   ftdi_txe_n   FTDI can accept TX bytes (active low)
//   ftdi_oe_n    FTDI output enable, FTDI drives bus when low
//   ftdi_rd_n    FTDI RX FIFO advance strobe (active low)
//   ftdi_wr_n    FTDI TX write strobe (active low)
//   ftdi_siwu    send-immediate / wake-up pulse (active low)
//   data_dir     1: FPGA drives ftdi_data, 0: tri-state
//   rx_ready     downstream RX buffer can accept a byte
//   rx_strobe    ftdi_data carries a valid RX byte this cycle
//   tx_avail     TX buffer presents a byte
//   tx_pop       TX byte consumed this cycle
//   tx_flush     level request for a send-immediate after pending TX data
//   busy         scheduler is not idle
// ---------------------------------------------------------------------------
module ft245_bus_sched #(
    parameter int unsigned MAX_BURST   = 64,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ftdi_rde_n,
    input  logic ftdi_txe_n,
    output logic ftdi_oe_n,
    output logic ftdi_rd_n,
    output logic ftdi_wr_n,
    output logic ftdi_siwu,
    output logic data_dir,
    input  logic rx_ready,
    output logic rx_strobe,
    input  logic tx_avail,
    output logic tx_pop,
    input  logic tx_flush,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_OE,
        S_RX_READ,
        S_RX_END,
        S_TURN,
        S_TX_WRITE,
        S_TX_END,
        S_SIWU
    } state_t;

    localparam logic [7:0] MAX_CNT   = 8'(MAX_BURST);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;            // bytes moved in the current grant
    logic [1:0] turn_q, turn_d;          // cycles spent in TURN
    logic       last_tx_q, last_tx_d;    // 1: last completed grant was TX
    logic       flush_armed_q, flush_armed_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic       rx_elig;
    logic       tx_elig;
    logic       at_max;
    logic [7:0] cnt_inc;
    logic       flush_req;

    assign rx_elig   = ~ftdi_rde_n & rx_ready;
    assign tx_elig   = ~ftdi_txe_n & tx_avail;
    assign at_max    = (cnt_q == MAX_CNT);
    assign cnt_inc   = cnt_q + 8'd1;
    // A flush pulse is only useful once the TX buffer has drained, and only
    // once per assertion of the tx_flush level.
    assign flush_req = tx_flush & ~tx_avail & flush_armed_q;

    // Raw (pre-reset-gating) output values produced by the FSM
    logic oe_n_c;
    logic rd_n_c;
    logic wr_n_c;
    logic siwu_c;
    logic dir_c;
    logic strobe_c;
    logic pop_c;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        turn_d        = turn_q;
        last_tx_d     = last_tx_q;
        // The flush request re-arms whenever tx_flush is seen low.
        flush_armed_d = flush_armed_q | ~tx_flush;

        oe_n_c   = 1'b1;
        rd_n_c   = 1'b1;
        wr_n_c   = 1'b1;
        siwu_c   = 1'b1;
        dir_c    = 1'b0;
        strobe_c = 1'b0;
        pop_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Round-robin on a tie: the direction not served last wins.
                if (rx_elig && (!tx_elig || last_tx_q)) begin
                    state_d = S_RX_OE;
                    cnt_d   = 8'd0;
                end else if (tx_elig) begin
                    state_d = S_TX_WRITE;
                    cnt_d   = 8'd0;
                end else if (flush_req) begin
                    state_d = S_SIWU;
                end
            end

            S_RX_OE: begin
                // One cycle of oe_n low before rd_n so the FTDI has the bus
                // turned around before the first byte is taken.
                oe_n_c  = 1'b0;
                state_d = S_RX_READ;
            end

            S_RX_READ: begin
                oe_n_c = 1'b0;
                // rd_n is held off combinationally when the sink stalls, so
                // the FTDI FIFO never advances past a byte nobody accepted.
                rd_n_c   = ~(rx_ready & ~at_max);
                strobe_c = ~rd_n_c & ~ftdi_rde_n;
                if (strobe_c) begin
                    cnt_d = cnt_inc;
                end
                if (ftdi_rde_n || !rx_ready || at_max ||
                    (strobe_c && (cnt_inc == MAX_CNT))) begin
                    state_d = S_RX_END;
                end
            end

            S_RX_END: begin
                last_tx_d = 1'b0;
                turn_d    = 2'd0;
                state_d   = S_TURN;
            end

            S_TURN: begin
                // Bus is released by the FTDI; nobody drives it here.
                if (turn_q == TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end

            S_TX_WRITE: begin
                dir_c  = 1'b1;
                wr_n_c = ~(tx_elig & ~at_max);
                pop_c  = ~wr_n_c;
                if (pop_c) begin
                    cnt_d = cnt_inc;
                end
                if (ftdi_txe_n || !tx_avail || at_max ||
                    (pop_c && (cnt_inc == MAX_CNT))) begin
                    state_d = S_TX_END;
                end
            end

            S_TX_END: begin
                last_tx_d = 1'b1;
                if (flush_req) begin
                    state_d = S_SIWU;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SIWU: begin
                siwu_c        = 1'b0;
                flush_armed_d = 1'b0;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            turn_q        <= 2'd0;
            last_tx_q     <= 1'b1;   // so RX wins the first tie
            flush_armed_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            turn_q        <= turn_d;
            last_tx_q     <= last_tx_d;
            flush_armed_q <= flush_armed_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Reset forces every strobe inactive in the very cycle it is asserted,
    // so a reset in the middle of a burst moves no further byte.
    assign ftdi_oe_n = oe_n_c | rst;
    assign ftdi_rd_n = rd_n_c | rst;
    assign ftdi_wr_n = wr_n_c | rst;
    assign ftdi_siwu = siwu_c | rst;
    assign data_dir  = dir_c & ~rst;
    assign rx_strobe = strobe_c & ~rst;
    assign tx_pop    = pop_c & ~rst;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft245_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_ft245_bus_sched
//
// Directed bench for ft245_bus_sched. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. A background monitor
// collects the grant order and bus-exclusion violations, and test tasks
// compare them.
// ---------------------------------------------------------------------------
module tb_ft245_bus_sched;

    localparam int MAX_BURST   = 64;
    localparam int TURN_CYCLES = 1;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic ftdi_rde_n = 1'b1;
    logic ftdi_txe_n = 1'b1;
    logic rx_ready   = 1'b0;
    logic tx_avail   = 1'b0;
    logic tx_flush   = 1'b0;
    logic ftdi_oe_n;
    logic ftdi_rd_n;
    logic ftdi_wr_n;
    logic ftdi_siwu;
    logic data_dir;
    logic rx_strobe;
    logic tx_pop;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    ft245_bus_sched #(
        .MAX_BURST  (MAX_BURST),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ftdi_rde_n(ftdi_rde_n),
        .ftdi_txe_n(ftdi_txe_n),
        .ftdi_oe_n (ftdi_oe_n),
        .ftdi_rd_n (ftdi_rd_n),
        .ftdi_wr_n (ftdi_wr_n),
        .ftdi_siwu (ftdi_siwu),
        .data_dir  (data_dir),
        .rx_ready  (rx_ready),
        .rx_strobe (rx_strobe),
        .tx_avail  (tx_avail),
        .tx_pop    (tx_pop),
        .tx_flush  (tx_flush),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Background monitor
    // -----------------------------------------------------------------------
    int   cyc         = 0;
    int   viol        = 0;
    int   gap_viol    = 0;
    int   ng          = 0;
    int   oe_rise_cyc = -1000;
    bit   grants [0:255];          // 0: RX grant, 1: TX grant
    logic prev_oe_n   = 1'b1;
    logic prev_dd     = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (!ftdi_oe_n && data_dir) viol++;
            if (!ftdi_rd_n && !ftdi_wr_n) viol++;
            if (rx_strobe && !rx_ready) viol++;
            if (tx_pop !== !ftdi_wr_n) viol++;
            if (prev_oe_n && !ftdi_oe_n) begin
                if (ng < 256) grants[ng] = 1'b0;
                ng++;
            end
            if (!prev_dd && data_dir) begin
                if (ng < 256) grants[ng] = 1'b1;
                ng++;
                if (cyc - oe_rise_cyc < TURN_CYCLES + 1) gap_viol++;
            end
            if (!prev_oe_n && ftdi_oe_n) oe_rise_cyc = cyc;
        end
        prev_oe_n = ftdi_oe_n;
        prev_dd   = data_dir;
    end

    task automatic drive_point;
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ftdi_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b want 1", ftdi_oe_n); end
        n_checks++; if (ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL reset_rd_n: got %b want 1", ftdi_rd_n); end
        n_checks++; if (ftdi_wr_n !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b want 1", ftdi_wr_n); end
        n_checks++; if (ftdi_siwu !== 1'b1) begin n_fail++; $display("FAIL reset_siwu: got %b want 1", ftdi_siwu); end
        n_checks++; if (data_dir !== 1'b0) begin n_fail++; $display("FAIL reset_data_dir: got %b want 0", data_dir); end
        n_checks++; if (rx_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_rx_strobe: got %b want 0", rx_strobe); end
        n_checks++; if (tx_pop !== 1'b0) begin n_fail++; $display("FAIL reset_tx_pop: got %b want 0", tx_pop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("test_reset done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_rx_burst;
        int n = 0;
        int cycles = 0;
        drive_point();
        ftdi_rde_n = 1'b0;
        rx_ready   = 1'b1;
        @(negedge clk);  // IDLE sees the request
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_idle_busy: got %b want 0", busy); end
        @(negedge clk);  // RX_OE
        n_checks++; if (ftdi_oe_n !== 1'b0) begin n_fail++; $display("FAIL rx_oe_oe_n: got %b want 0", ftdi_oe_n); end
        n_checks++; if (ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL rx_oe_rd_n: got %b want 1", ftdi_rd_n); end
        n_checks++; if (rx_strobe !== 1'b0) begin n_fail++; $display("FAIL rx_oe_strobe: got %b want 0", rx_strobe); end
        while (n < 10 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (rx_strobe === 1'b1) n++;
        end
        n_checks++; if (n != 10) begin n_fail++; $display("FAIL rx_strobe_count: got %0d want 10", n); end
        n_checks++; if (cycles != 10) begin n_fail++; $display("FAIL rx_read_cycles: got %0d want 10", cycles); end
        drive_point();
        ftdi_rde_n = 1'b1;
        @(negedge clk);  // still RX_READ, nothing to take
        n_checks++; if (rx_strobe !== 1'b0) begin n_fail++; $display("FAIL rx_extra_strobe: got %b want 0", rx_strobe); end
        n_checks++; if (ftdi_oe_n !== 1'b0) begin n_fail++; $display("FAIL rx_exit_oe_n: got %b want 0", ftdi_oe_n); end
        @(negedge clk);  // RX_END
        n_checks++; if (ftdi_oe_n !== 1'b1) begin n_fail++; $display("FAIL rx_end_oe_n: got %b want 1", ftdi_oe_n); end
        n_checks++; if (ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL rx_end_rd_n: got %b want 1", ftdi_rd_n); end
        @(negedge clk);  // TURN
        n_checks++; if (busy !== 1'b1 || data_dir !== 1'b0) begin n_fail++; $display("FAIL rx_turn: got busy=%b dir=%b want busy=1 dir=0", busy, data_dir); end
        @(negedge clk);  // IDLE after a single TURN cycle
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_turn_len: got busy=%b want 0", busy); end
        drive_point();
        rx_ready = 1'b0;
        $display("test_rx_burst done: %0d strobes", n);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_tx_burst;
        int pops = 0;
        int wrl = 0;
        drive_point();
        ftdi_txe_n = 1'b0;
        tx_avail   = 1'b1;
        @(negedge clk);  // IDLE grant
        repeat (64) begin
            @(negedge clk);
            if (tx_pop === 1'b1) pops++;
            if (ftdi_wr_n === 1'b0) wrl++;
        end
        n_checks++; if (pops != 64) begin n_fail++; $display("FAIL tx_pop_count: got %0d want 64", pops); end
        n_checks++; if (wrl != 64) begin n_fail++; $display("FAIL tx_wr_low_count: got %0d want 64", wrl); end
        @(negedge clk);  // TX_END
        n_checks++; if (tx_pop !== 1'b0 || ftdi_wr_n !== 1'b1) begin n_fail++; $display("FAIL tx_end_strobes: got pop=%b wr_n=%b want 0/1", tx_pop, ftdi_wr_n); end
        n_checks++; if (data_dir !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tx_end_dir: got dir=%b busy=%b want 0/1", data_dir, busy); end
        @(negedge clk);  // IDLE
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tx_idle_busy: got %b want 0", busy); end
        @(negedge clk);  // re-grant
        n_checks++; if (tx_pop !== 1'b1 || data_dir !== 1'b1) begin n_fail++; $display("FAIL tx_regrant: got pop=%b dir=%b want 1/1", tx_pop, data_dir); end
        drive_point();
        ftdi_txe_n = 1'b1;
        tx_avail   = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tx_settle_busy: got %b want 0", busy); end
        $display("test_tx_burst done: %0d pops", pops);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_rx_ready_drop;
        int n = 0;
        int cycles = 0;
        int extra = 0;
        drive_point();
        ftdi_rde_n = 1'b0;
        rx_ready   = 1'b1;
        while (n < 5 && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (rx_strobe === 1'b1) n++;
        end
        drive_point();
        rx_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (ftdi_rd_n !== 1'b1 || rx_strobe !== 1'b0) begin n_fail++; $display("FAIL drop_rd_n: got rd_n=%b strobe=%b want 1/0", ftdi_rd_n, rx_strobe); end
        repeat (10) begin
            @(negedge clk);
            if (rx_strobe === 1'b1) extra++;
        end
        n_checks++; if (n + extra != 5) begin n_fail++; $display("FAIL drop_strobe_count: got %0d want 5", n + extra); end
        n_checks++; if (busy !== 1'b0 || ftdi_oe_n !== 1'b1) begin n_fail++; $display("FAIL drop_no_regrant: got busy=%b oe_n=%b want 0/1", busy, ftdi_oe_n); end
        drive_point();
        ftdi_rde_n = 1'b1;
        $display("test_rx_ready_drop done: %0d strobes", n + extra);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_flush;
        int n = 0;
        int cycles = 0;
        int pops_after = 0;
        int siwu_low = 0;
        int siwu_idx = -1;
        drive_point();
        ftdi_txe_n = 1'b0;
        tx_avail   = 1'b1;
        tx_flush   = 1'b1;
        while (n < 3 && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (tx_pop === 1'b1) n++;
        end
        drive_point();
        tx_avail = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (tx_pop === 1'b1) pops_after++;
            if (ftdi_siwu === 1'b0) begin
                siwu_low++;
                if (siwu_idx < 0) siwu_idx = i;
            end
        end
        n_checks++; if (n + pops_after != 3) begin n_fail++; $display("FAIL flush_pop_count: got %0d want 3", n + pops_after); end
        n_checks++; if (siwu_low != 1) begin n_fail++; $display("FAIL flush_siwu_count: got %0d want 1", siwu_low); end
        n_checks++; if (siwu_idx != 3) begin n_fail++; $display("FAIL flush_siwu_pos: got %0d want 3", siwu_idx); end
        // Drop and re-raise tx_flush with nothing pending: one new pulse.
        drive_point();
        tx_flush = 1'b0;
        drive_point();
        tx_flush = 1'b1;
        siwu_low = 0;
        repeat (6) begin
            @(negedge clk);
            if (ftdi_siwu === 1'b0) siwu_low++;
        end
        n_checks++; if (siwu_low != 1) begin n_fail++; $display("FAIL flush_rearm_count: got %0d want 1", siwu_low); end
        drive_point();
        tx_flush   = 1'b0;
        ftdi_txe_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("test_flush done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_alternate;
        int base;
        int cycles = 0;
        bit want;
        drive_point();
        rst = 1'b1;
        drive_point();
        rst = 1'b0;
        base = ng;
        ftdi_rde_n = 1'b0;
        rx_ready   = 1'b1;
        ftdi_txe_n = 1'b0;
        tx_avail   = 1'b1;
        while ((ng - base) < 4 && cycles < 600) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++; if ((ng - base) < 4) begin n_fail++; $display("FAIL alt_grant_count: got %0d want >=4", ng - base); end
        for (int k = 0; k < 4; k++) begin
            want = k[0];
            n_checks++;
            if (base + k >= 256 || grants[base + k] !== want) begin
                n_fail++;
                $display("FAIL alt_grant_%0d: got %b want %b", k, (base + k < 256) ? grants[base + k] : 1'b0, want);
            end
        end
        drive_point();
        ftdi_rde_n = 1'b1;
        rx_ready   = 1'b0;
        ftdi_txe_n = 1'b1;
        tx_avail   = 1'b0;
        repeat (8) @(negedge clk);
        $display("test_alternate done: %0d grants", ng - base);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid;
        int n = 0;
        int cycles = 0;
        drive_point();
        ftdi_rde_n = 1'b0;
        rx_ready   = 1'b1;
        while (n < 3 && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (rx_strobe === 1'b1) n++;
        end
        drive_point();
        rst = 1'b1;      // would have been byte 4
        @(negedge clk);
        n_checks++; if (rx_strobe !== 1'b0 || ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_strobe: got strobe=%b rd_n=%b want 0/1", rx_strobe, ftdi_rd_n); end
        drive_point();
        rst        = 1'b0;
        ftdi_rde_n = 1'b1;
        rx_ready   = 1'b0;
        @(negedge clk);
        n_checks++; if (ftdi_oe_n !== 1'b1 || ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_bus: got oe_n=%b rd_n=%b want 1/1", ftdi_oe_n, ftdi_rd_n); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        $display("test_reset_mid done: %0d strobes before reset", n);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_invariants;
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL bus_exclusion: got %0d violations want 0", viol); end
        n_checks++; if (gap_viol != 0) begin n_fail++; $display("FAIL turn_gap: got %0d violations want 0", gap_viol); end
        $display("test_invariants done");
    endtask

    initial begin
        test_reset();
        test_rx_burst();
        test_tx_burst();
        test_rx_ready_drop();
        test_flush();
        test_alternate();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
